// File: rtl/tracer_load_trace_ctrl_pkg.sv
// rtl/tracer_load_trace_ctrl_pkg.sv - shared constants and FSM encoding for the trace buffer reader
package tracer_pkg;

  localparam logic [10:0] TRACE_BASE_WORD = 11'd1314;
  localparam int          TRACE_NUM_WORDS = 32;
  localparam int          TRACE_IDX_W     = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } load_state_e;

endpackage

// File: rtl/tracer_load_trace_ctrl_if.sv
// rtl/tracer_load_trace_ctrl_if.sv - sample stream from the trace reader towards the host/DMA path
interface tracer_load_trace_ctrl_if;
  import tracer_pkg::*;

  logic                   trace_valid;
  logic                   trace_ready;
  logic [15:0]            trace_data;
  logic [TRACE_IDX_W-1:0] trace_index;
  logic                   trace_last;

  modport master (
    output trace_valid, trace_data, trace_index, trace_last,
    input  trace_ready
  );

  modport slave (
    input  trace_valid, trace_data, trace_index, trace_last,
    output trace_ready
  );

endinterface

// File: rtl/tracer_load_trace_ctrl_fifo.sv
// rtl/tracer_load_trace_ctrl_fifo.sv - word skid FIFO between the BRAM read pipeline and the unpacker
module tracer_load_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                     s_axi_aclk,
  input  logic                     s_axi_aresetn,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Storage carries no reset; head is only consumed while the FIFO is non-empty.
  always_ff @(posedge s_axi_aclk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign count = cnt;
  assign empty = (cnt == '0);
  assign full  = (cnt == (AW+1)'(DEPTH));

endmodule

// File: rtl/tracer_load_trace_ctrl.sv
// rtl/tracer_load_trace_ctrl.sv - trace block reader: BRAM fetch, unpack, sample stream; TRACER_LOAD_CHKSUM_EN adds trace_chksum
module tracer_load_trace_ctrl
  import tracer_pkg::*;
#(
  parameter logic [10:0] BASE_WORD  = TRACE_BASE_WORD,
  parameter int          NUM_WORDS  = TRACE_NUM_WORDS,
  parameter int          RD_LATENCY = 1,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                      s_axi_aclk,
  input  logic                      s_axi_aresetn,
  input  logic                      load_start,
  output logic                      tracer_buf_en,
  output logic [31:0]               tracer_buf_addr,
  input  logic [31:0]               tracer_buf_din,
  tracer_load_trace_ctrl_if.master  trace,
  output logic                      load_busy,
  output logic                      load_done
`ifdef TRACER_LOAD_CHKSUM_EN
  ,
  output logic [15:0]               trace_chksum
`endif
);

  localparam int          CW         = $clog2(FIFO_DEPTH) + 1;
  localparam int          RW         = $clog2(NUM_WORDS);
  localparam logic [RW-1:0] LAST_RD  = RW'(NUM_WORDS - 1);
  localparam logic [CW:0] CREDIT_MAX = (CW+1)'(FIFO_DEPTH);
  localparam logic [31:0] BASE_ADDR  = {19'd0, BASE_WORD, 2'b00};

  load_state_e           state;
  logic [RW-1:0]         rd_cnt;
  logic [CW-1:0]         outs;
  logic [RD_LATENCY-1:0] vld_sr;
  logic [CW-1:0]         fifo_count;
  logic [31:0]           head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  issue;
  logic                  push;
  logic                  accept;
  logic                  pop;
  logic                  half;
  logic [4:0]            word_cnt;
  logic [CW:0]           credit;

  assign credit = {1'b0, fifo_count} + {1'b0, outs};

  always_comb begin
    issue = 1'b0;
    case (state)
      IDLE:    issue = load_start;
      FETCH:   issue = (credit < CREDIT_MAX);
      default: issue = 1'b0;
    endcase
  end

  // The first read goes out on the IDLE->FETCH edge so the first sample lands RD_LATENCY+2 after start.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state           <= IDLE;
      tracer_buf_en   <= 1'b0;
      tracer_buf_addr <= BASE_ADDR;
      rd_cnt          <= '0;
      outs            <= '0;
      load_done       <= 1'b0;
    end else begin
      tracer_buf_en <= issue;
      load_done     <= 1'b0;
      outs          <= outs + CW'(issue) - CW'(push);
      case (state)
        IDLE: if (load_start) begin
          state           <= FETCH;
          tracer_buf_addr <= BASE_ADDR;
          rd_cnt          <= RW'(1);
        end
        FETCH: if (issue) begin
          tracer_buf_addr <= {19'd0, BASE_WORD + 11'(rd_cnt), 2'b00};
          rd_cnt          <= rd_cnt + RW'(1);
          if (rd_cnt == LAST_RD) state <= DRAIN;
        end
        DRAIN: if (accept && trace.trace_last && outs == '0) begin
          state     <= IDLE;
          load_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      vld_sr <= '0;
    end else begin
      vld_sr[0] <= tracer_buf_en;
      for (int i = 1; i < RD_LATENCY; i++) vld_sr[i] <= vld_sr[i-1];
    end
  end

  assign push = vld_sr[RD_LATENCY-1] && !fifo_full;

  tracer_load_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (32)
  ) u_fifo (
    .s_axi_aclk    (s_axi_aclk),
    .s_axi_aresetn (s_axi_aresetn),
    .push          (push),
    .push_data     (tracer_buf_din),
    .pop           (pop),
    .head          (head),
    .full          (fifo_full),
    .empty         (fifo_empty),
    .count         (fifo_count)
  );

  assign accept = trace.trace_valid && trace.trace_ready;
  assign pop    = accept && half;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      half     <= 1'b0;
      word_cnt <= '0;
    end else if (accept) begin
      half <= ~half;
      if (half) word_cnt <= word_cnt + 5'd1;
    end
  end

  assign trace.trace_valid = !fifo_empty;
  assign trace.trace_data  = fifo_empty ? 16'd0 : (half ? head[31:16] : head[15:0]);
  assign trace.trace_index = {word_cnt, half};
  assign trace.trace_last  = !fifo_empty && (&{word_cnt, half});
  assign load_busy         = (state != IDLE);

`ifdef TRACER_LOAD_CHKSUM_EN
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn)                  trace_chksum <= 16'd0;
    else if (state == IDLE && load_start) trace_chksum <= 16'd0;
    else if (accept)                     trace_chksum <= trace_chksum + trace.trace_data;
  end
`endif

endmodule

// File: tb/tb_tracer_load_trace_ctrl.sv
// tb/tb_tracer_load_trace_ctrl.sv - scoreboard bench for the trace block reader
module tb_tracer_load_trace_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start = 1'b0;
  logic        en;
  logic [31:0] addr;
  logic [31:0] din = 32'd0;
  logic        busy;
  logic        done;
`ifdef TRACER_LOAD_CHKSUM_EN
  logic [15:0] chksum;
`endif

  tracer_load_trace_ctrl_if tif();

  tracer_load_trace_ctrl dut (
    .s_axi_aclk      (clk),
    .s_axi_aresetn   (rst_n),
    .load_start      (load_start),
    .tracer_buf_en   (en),
    .tracer_buf_addr (addr),
    .tracer_buf_din  (din),
    .trace           (tif),
    .load_busy       (busy),
    .load_done       (done)
`ifdef TRACER_LOAD_CHKSUM_EN
    ,
    .trace_chksum    (chksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [5:0]  i;
    logic        l;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] bram [32];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          ready_mode = 0;
  int          blk_issue = 0, blk_pop = 0;
  int          credit_err = 0, stall_err = 0, addr_err = 0, done_cnt = 0;
  int          last_addr = 0;
  logic [15:0] model_sum = 16'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // BRAM with one cycle read latency; the word field is offset from the trace base.
  always @(posedge clk) begin
    if (en) begin
      logic [10:0] w;
      w = addr[12:2] - 11'd1314;
      din <= bram[w[4:0]];
    end
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       tif.trace_ready = 1'b1;
      2:       tif.trace_ready = 1'b0;
      default: tif.trace_ready = 1'($urandom_range(0, 1));
    endcase
  end

  logic        prev_stall = 1'b0;
  logic [15:0] prev_data;
  logic [5:0]  prev_idx;

  always @(negedge clk) begin
    if (!rst_n) begin
      blk_issue  = 0;
      blk_pop    = 0;
      prev_stall = 1'b0;
    end else begin
      if (load_start && !busy) begin
        blk_issue = 0;
        blk_pop   = 0;
      end
      if (en) begin
        blk_issue++;
        if (blk_issue - blk_pop > 4) credit_err++;
        if (addr != 32'(5256 + 4 * (blk_issue - 1))) addr_err++;
        last_addr = int'(addr);
      end
      if (prev_stall && !(tif.trace_valid && tif.trace_data == prev_data && tif.trace_index == prev_idx))
        stall_err++;
      prev_stall = tif.trace_valid && !tif.trace_ready;
      prev_data  = tif.trace_data;
      prev_idx   = tif.trace_index;
      if (tif.trace_valid && tif.trace_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_sample", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("trace_data", tif.trace_data, e.d);
          chk("trace_index", tif.trace_index, e.i);
          chk("trace_last", tif.trace_last, e.l);
        end
        if (tif.trace_index[0]) blk_pop++;
      end
      if (done) done_cnt++;
    end
  end

  task automatic fill_bram(input bit rnd);
    for (int k = 0; k < 32; k++)
      bram[k] = rnd ? $urandom : {16'(2 * k + 1), 16'(2 * k)};
  endtask

  task automatic start_block();
    @(posedge clk);
    #1 load_start = 1'b1;
    model_sum = 16'd0;
    for (int s = 0; s < 64; s++) begin
      exp_t e;
      e.d = s[0] ? bram[s / 2][31:16] : bram[s / 2][15:0];
      e.i = 6'(s);
      e.l = (s == 63);
      model_sum = model_sum + e.d;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1 load_start = 1'b0;
  endtask

  task automatic wait_index(input int idx);
    int t = 0;
    while (!(tif.trace_valid && tif.trace_index == 6'(idx)) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("wait_index_timeout", (t < 3000), 1);
  endtask

  task automatic finish_block(input int done0, input int cred0, input int stall0, input int addr0);
    int t = 0;
    while (done_cnt == done0 && t < 4000) begin
      @(posedge clk);
      t++;
    end
    chk("done_timeout", (t < 4000), 1);
    repeat (12) @(negedge clk);
    chk("load_done_pulses", done_cnt - done0, 1);
    chk("samples_left", sbq.size(), 0);
    chk("reads_issued", blk_issue, 32);
    chk("credit_violations", credit_err - cred0, 0);
    chk("stall_instability", stall_err - stall0, 0);
    chk("addr_sequence", addr_err - addr0, 0);
    chk("busy_after_done", busy, 0);
`ifdef TRACER_LOAD_CHKSUM_EN
    chk("trace_chksum", chksum, model_sum);
`endif
  endtask

  task automatic run_block(input int mode, input bit lat_chk, input int poke_idx);
    int d0 = done_cnt, c0 = credit_err, s0 = stall_err, a0 = addr_err;
    int k = 0;
    ready_mode = (mode == 2) ? 2 : mode;
    start_block();
    if (lat_chk) begin
      do begin
        @(negedge clk);
        k++;
      end while (!tif.trace_valid && k < 12);
      chk("first_valid_latency", k, 3);
    end
    if (mode == 2) begin
      repeat (100) @(negedge clk);
      chk("stalled_reads", blk_issue, 4);
      chk("stalled_last_addr", last_addr, 5268);
      chk("stalled_no_sample", sbq.size(), 64);
      ready_mode = 1;
    end
    if (poke_idx >= 0) begin
      wait_index(poke_idx);
      @(posedge clk);
      #1 load_start = 1'b1;
      @(posedge clk);
      #1 load_start = 1'b0;
    end
    finish_block(d0, c0, s0, a0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_en", en, 0);
    chk("rst_addr", addr, 32'd5256);
    chk("rst_valid", tif.trace_valid, 0);
    chk("rst_data", tif.trace_data, 0);
    chk("rst_index", tif.trace_index, 0);
    chk("rst_last", tif.trace_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
  endtask

  initial begin
    tif.trace_ready = 1'b1;
    fill_bram(1'b0);
    repeat (3) @(negedge clk);
    chk_reset_vals();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_block(0, 1'b1, -1);
`ifdef TRACER_LOAD_CHKSUM_EN
    chk("chksum_fixed_pattern", chksum, 16'd2016);
`endif
    run_block(1, 1'b0, -1);
    run_block(2, 1'b0, -1);
    run_block(1, 1'b0, 20);

    ready_mode = 1;
    start_block();
    wait_index(30);
    @(posedge clk);
    #2 rst_n = 1'b0;
    sbq.delete();
    @(negedge clk);
    chk_reset_vals();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    run_block(1, 1'b0, -1);

    for (int b = 0; b < 3; b++) begin
      fill_bram(1'b1);
      run_block(1, 1'b0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
